// File: rtl/dat_mem_clr.sv
// Single-port word memory with a hardware clear sweep over the upper region.
// The clear runs automatically out of reset and again on each clr_req.
module dat_mem_clr #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int DEPTH  = 256,
    parameter int CLR_LO = 61
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          clr_req,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          busy,
    output logic          err
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] PTR_LO = AW'(CLR_LO);
    localparam logic [AW-1:0] PTR_HI = AW'(DEPTH - 1);
    localparam logic [AW:0]   LIMIT  = (AW + 1)'(DEPTH);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] mem [DEPTH];

    logic acc;
    logic in_range;
    logic clr_last;

    assign acc      = req && ready;
    assign in_range = {1'b0, addr} < LIMIT;
    assign clr_last = (clr_ptr == PTR_HI);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        unique case (state_q)
            IDLE:    ready = 1'b1;
            CLEAR:   busy  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // A clr_req arriving mid-sweep is ignored: the pointer only reloads in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_ptr <= PTR_LO;
        end else if (state_q == IDLE) begin
            if (clr_req) begin
                clr_ptr <= PTR_LO;
            end
        end else if (!clr_last) begin
            clr_ptr <= clr_ptr + AW'(1);
        end
    end

    // Storage is deliberately not reset so the low region survives reset.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_ptr] <= '0;
        end else if (acc && we && in_range) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= acc && !we;
            err    <= acc && !in_range;
            if (acc && !we) begin
                rdata <= in_range ? mem[addr] : '0;
            end
        end
    end

endmodule
